// File: rtl/pulse_sync_pkg.sv
// Shared types for the toggle-based pulse synchronizer TX pacer.
// Contents: handshake state encoding used by pulse_sync_tx_pacer.
package pulse_sync_pkg;

    localparam int unsigned STATE_W = 2;

    // Handshake progress of the single in-flight toggle.
    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_sync_tx_pacer_bit_sync.sv
// Multi-flop synchronizer for a single level crossing into the local clock.
// Ports:
//   clk  in  destination clock
//   rst  in  synchronous active-high reset, clears every stage
//   d    in  asynchronous level
//   q    out synchronized level (last stage)
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the incoming level through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_sync_tx_pacer.sv
// TX-side pacer: queues tx_pulse events in a saturating counter and launches
// them one at a time as toggles on tx_level, waiting for the returned ack level
// plus a minimum gap before each new launch.
// Ports:
//   tx_clk        in  TX clock
//   tx_rst        in  synchronous active-high reset
//   tx_pulse      in  single-cycle event request
//   clr_overflow  in  clears sticky overflow (a same-cycle drop wins)
//   rx_ack_level  in  tx_level echoed back from the RX domain (async)
//   tx_level      out toggle level crossing to RX
//   pending       out events accepted but not yet launched
//   busy          out handshake in flight
//   overflow      out sticky: an event was dropped at saturation
module pulse_sync_tx_pacer
    import pulse_sync_pkg::*;
#(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             tx_clk,
    input  logic             tx_rst,
    input  logic             tx_pulse,
    input  logic             clr_overflow,
    input  logic             rx_ack_level,
    output logic             tx_level,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);

    state_e             state;
    state_e             state_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic               level_nxt;
    logic [CNT_W-1:0]   pending_nxt;
    logic               ovf_set_c;
    logic               launch_c;
    logic               ack_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (tx_clk),
        .rst (tx_rst),
        .d   (rx_ack_level),
        .q   (ack_s)
    );

    // Launch only from the registered count, never from tx_pulse directly.
    assign launch_c = (state == IDLE) && (pending != '0);

    // Saturating event counter; a simultaneous request and launch cancel out.
    always_comb begin
        pending_nxt = pending;
        ovf_set_c   = 1'b0;
        case ({tx_pulse, launch_c})
            2'b10: begin
                if (pending == '1) begin
                    ovf_set_c = 1'b1;
                end else begin
                    pending_nxt = pending + CNT_W'(1);
                end
            end
            2'b01:   pending_nxt = pending - CNT_W'(1);
            default: pending_nxt = pending;
        endcase
    end

    // Handshake sequencing: launch, wait for echo, enforce the gap.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        level_nxt = tx_level;
        case (state)
            IDLE: begin
                if (launch_c) begin
                    level_nxt = ~tx_level;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == tx_level) begin
                    gap_nxt   = '0;
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            tx_level <= 1'b0;
            pending  <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            tx_level <= level_nxt;
            pending  <= pending_nxt;
            busy     <= (state_nxt != IDLE);
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_sync_tx_pacer.sv
// Directed self-checking bench for pulse_sync_tx_pacer.
// dut_a: default parameters, ack source selectable (loopback / stuck 0 / 10-cycle delay).
// dut_b: CNT_W=2 with ack stuck at 0. dut_g: GAP_CYC=0 with loopback ack.
module tb_pulse_sync_tx_pacer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       pulse_a, clr_a, ack_a;
    logic       pulse_b, clr_b;
    logic       pulse_g, clr_g;
    logic [1:0] ack_mode;
    logic [9:0] dly;

    logic       level_a, busy_a, ovf_a;
    logic [3:0] pend_a;
    logic       level_b, busy_b, ovf_b;
    logic [1:0] pend_b;
    logic       level_g, busy_g, ovf_g;
    logic [3:0] pend_g;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   exp_q[$];
    logic prev_lvl;
    int   prev_pend;

    always_ff @(posedge clk) begin
        if (rst) dly <= '0;
        else     dly <= {dly[8:0], level_a};
    end

    assign ack_a = (ack_mode == 2'd0) ? level_a :
                   (ack_mode == 2'd1) ? 1'b0 : dly[9];

    pulse_sync_tx_pacer dut_a (
        .tx_clk(clk), .tx_rst(rst), .tx_pulse(pulse_a), .clr_overflow(clr_a),
        .rx_ack_level(ack_a), .tx_level(level_a), .pending(pend_a),
        .busy(busy_a), .overflow(ovf_a)
    );

    pulse_sync_tx_pacer #(.CNT_W(2)) dut_b (
        .tx_clk(clk), .tx_rst(rst), .tx_pulse(pulse_b), .clr_overflow(clr_b),
        .rx_ack_level(1'b0), .tx_level(level_b), .pending(pend_b),
        .busy(busy_b), .overflow(ovf_b)
    );

    pulse_sync_tx_pacer #(.GAP_CYC(0)) dut_g (
        .tx_clk(clk), .tx_rst(rst), .tx_pulse(pulse_g), .clr_overflow(clr_g),
        .rx_ack_level(level_g), .tx_level(level_g), .pending(pend_g),
        .busy(busy_g), .overflow(ovf_g)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // One reset cycle; returns at the first post-reset sampling point.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pulse_a = 1'b0; clr_a = 1'b0;
        pulse_b = 1'b0; clr_b = 1'b0;
        pulse_g = 1'b0; clr_g = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        exp_q.delete();
    endtask

    // Pop the expected launch cycle whenever the watched level toggles.
    task automatic sb_tick(input logic lvl);
        if (lvl !== prev_lvl) begin
            if (exp_q.size() == 0) chk("unexpected_toggle", 32'(cyc), 32'hFFFF_FFFF);
            else                   chk("toggle_cycle", 32'(cyc), 32'(exp_q.pop_front()));
            prev_lvl = lvl;
        end
    endtask

    initial begin
        rst = 1'b1; ack_mode = 2'd0;
        pulse_a = 1'b0; clr_a = 1'b0;
        pulse_b = 1'b0; clr_b = 1'b0;
        pulse_g = 1'b0; clr_g = 1'b0;

        // Reset state of all instances.
        do_reset();
        chk("rst_level", 32'(level_a), 32'd0);
        chk("rst_pend",  32'(pend_a),  32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_ovf",   32'(ovf_a),   32'd0);
        chk("rst_pend_b", 32'(pend_b), 32'd0);
        chk("rst_level_g", 32'(level_g), 32'd0);

        // Single pulse with loopback ack.
        pulse_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulse_a = 1'b0;
            chk("t1_pend",  32'(pend_a),  32'(cyc == 1));
            chk("t1_level", 32'(level_a), 32'(cyc >= 2));
            chk("t1_busy",  32'(busy_a),  32'(cyc >= 2 && cyc <= 6));
        end

        // Burst of five pulses, loopback; scoreboard of launch cycles.
        do_reset();
        prev_lvl = level_a;
        pulse_a = 1'b1;
        exp_q.push_back(2);
        while (cyc < 32) begin
            tick();
            pulse_a = (cyc <= 4);
            if (pulse_a) exp_q.push_back(2 + 6 * cyc);
            sb_tick(level_a);
            if (cyc >= 1 && cyc <= 5)
                chk("t2_pend", 32'(pend_a), 32'((cyc == 1) ? 1 : cyc - 1));
        end
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_level", 32'(level_a), 32'd1);
        chk("t2_ovf",   32'(ovf_a),   32'd0);
        chk("t2_busy",  32'(busy_a),  32'd0);
        chk("t2_pend_end", 32'(pend_a), 32'd0);

        // Saturation with CNT_W=2 and a stuck ack.
        do_reset();
        pulse_b = 1'b1;
        while (cyc < 5) begin
            tick();
            pulse_b = (cyc <= 4);
            if (cyc == 4) begin
                chk("t3_ovf_pre",  32'(ovf_b),  32'd0);
                chk("t3_pend_pre", 32'(pend_b), 32'd3);
            end
        end
        chk("t3_ovf",   32'(ovf_b),   32'd1);
        chk("t3_pend",  32'(pend_b),  32'd3);
        chk("t3_level", 32'(level_b), 32'd1);
        pulse_b = 1'b0; clr_b = 1'b1;
        tick();
        chk("t3_clr", 32'(ovf_b), 32'd0);
        pulse_b = 1'b1; clr_b = 1'b1;
        tick();
        chk("t3_set_beats_clr", 32'(ovf_b), 32'd1);
        pulse_b = 1'b0; clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("t3_clr2", 32'(ovf_b), 32'd0);
        chk("t3_one_launch", 32'(level_b), 32'd1);

        // Ack delayed 10 cycles: second launch only after ack_s matches plus gap.
        ack_mode = 2'd2;
        do_reset();
        prev_lvl = level_a;
        pulse_a = 1'b1;
        exp_q.push_back(2);
        tick();
        exp_q.push_back(18);
        sb_tick(level_a);
        tick();
        pulse_a = 1'b0;
        sb_tick(level_a);
        while (cyc < 25) begin
            tick();
            sb_tick(level_a);
            if (cyc >= 14 && cyc <= 17)
                chk("t4_busy", 32'(busy_a), 32'(cyc <= 16));
        end
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT_ACK with three events queued.
        ack_mode = 2'd1;
        do_reset();
        pulse_a = 1'b1;
        while (cyc < 4) begin
            tick();
            pulse_a = (cyc <= 3);
        end
        chk("t5_pend_pre", 32'(pend_a), 32'd3);
        chk("t5_busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_level", 32'(level_a), 32'd0);
        chk("t5_pend",  32'(pend_a),  32'd0);
        chk("t5_busy",  32'(busy_a),  32'd0);
        chk("t5_ovf",   32'(ovf_a),   32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t5_quiet", 32'({level_a, busy_a}), 32'd0);
        end

        // GAP_CYC=0 with continuous backlog: period 4, one decrement per launch.
        do_reset();
        prev_lvl  = level_g;
        prev_pend = 0;
        pulse_g = 1'b1;
        exp_q.push_back(2);
        while (cyc < 28) begin
            tick();
            pulse_g = (cyc <= 5);
            if (pulse_g) exp_q.push_back(2 + 4 * cyc);
            if (cyc >= 7 && level_g !== prev_lvl)
                chk("t6_dec", 32'(pend_g), 32'(prev_pend - 1));
            sb_tick(level_g);
            prev_pend = int'(pend_g);
        end
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_pend_end", 32'(pend_g), 32'd0);
        chk("t6_busy_end", 32'(busy_g), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_sync_tx_pacer.md
# pulse_sync_tx_pacer

TX-side pacing front end for the toggle-based pulse synchronizer. Accepts `tx_pulse` events at any rate, queues them in a saturating counter, and launches them one at a time as toggles on `tx_level`. The next toggle waits until the RX side returns the level (`rx_ack_level`) and a minimum gap has elapsed, so the RX double-flop never misses a toggle regardless of the RX clock ratio. Sits entirely in the TX clock domain, directly ahead of the crossing.

## Interface
- `CNT_W`, 4: pending-event counter width; max queued events = 2^CNT_W-1.
- `GAP_CYC`, 2: idle cycles after ack before the next launch; 0 allowed.
- `SYNC_STAGES`, 2: flops in the ack synchronizer; ≥2.
- `tx_clk`  in  1  TX clock.
- `tx_rst`  in  1  reset; one clock, synchronous, active-high.
- `tx_pulse`  in  1  single-cycle event request; back-to-back allowed.
- `clr_overflow`  in  1  clears the sticky `overflow`.
- `rx_ack_level`  in  1  level returned from RX domain (RX-synchronized copy of `tx_level`); asynchronous to `tx_clk`.
- `tx_level`  out  1  registered toggle level crossing to RX.
- `pending`  out  CNT_W  events accepted but not yet launched.
- `busy`  out  1  handshake in flight (state ≠ IDLE).
- `overflow`  out  1  sticky: an event was dropped.

## Operation
- Reset values: `tx_level`=0, `pending`=0, `busy`=0, `overflow`=0, ack sync flops=0, state IDLE, gap counter 0.
- Ack sync: `rx_ack_level` through SYNC_STAGES flops → `ack_s`. Only `ack_s` is used.
- Counter: +1 on `tx_pulse`; −1 on launch; both in the same cycle → unchanged. At 2^CNT_W-1 with `tx_pulse` and no launch: event dropped, count holds, `overflow` set. Set beats `clr_overflow` in the same cycle.
- FSM:
  - IDLE: if `pending`≠0 → toggle `tx_level`, decrement, go WAIT_ACK.
  - WAIT_ACK: when `ack_s`==`tx_level` → GAP (or IDLE directly if GAP_CYC=0).
  - GAP: count GAP_CYC cycles, then IDLE.
- No ack timeout; WAIT_ACK holds indefinitely. `pending` keeps accumulating meanwhile.
- Both domains must be reset together. A stale `rx_ack_level` after a TX-only reset is unsupported: it can falsely complete the first handshake.

## Timing
- `tx_pulse` high in cycle 0 → `pending`=1 in cycle 1 → `tx_level` toggles and `busy`=1 in cycle 2.
- Launch never uses `tx_pulse` combinationally. Minimum request-to-toggle latency is 2 cycles.
- With `rx_ack_level` tied to `tx_level`: `ack_s` matches SYNC_STAGES cycles after the toggle. GAP is entered 1 cycle later.
- Toggle period under a continuous backlog = SYNC_STAGES + GAP_CYC + 2. Defaults give 6.
- `tx_rst` in any state → reset values in the next cycle. Queued events are discarded.

## Structure
- Package `pulse_sync_pkg`: state enum typedef (IDLE, WAIT_ACK, GAP).
- Sub-module `bit_sync`: parameterized SYNC_STAGES flop chain with synchronous active-high reset. Used for `rx_ack_level`.
- Top holds the counter, FSM, gap counter and `tx_level` register.

## Test plan
- Single pulse, loopback ack, defaults: pulse cycle 0 → `pending` 1 at cycle 1, `tx_level` 0→1 at cycle 2, `busy` high cycles 2–6, IDLE at cycle 7.
- Burst of 5 pulses at cycles 0–4, loopback: `pending` = 1,1,2,3,4 over cycles 1–5. Toggles at cycles 2,8,14,20,26. Final `tx_level`=1, `overflow`=0.
- CNT_W=2, `rx_ack_level` held 0, pulses at cycles 0–4: one launch, `pending` saturates at 3, `overflow`=1 at cycle 5. `clr_overflow` pulse → `overflow`=0 next cycle.
- Ack = `tx_level` delayed 10 cycles: no second toggle before `ack_s` matches. At least GAP_CYC cycles of `busy` remain after the match.
- `tx_rst` for one cycle during WAIT_ACK with `pending`=3: next cycle all outputs 0. No toggle follows without new pulses.
- GAP_CYC=0 with a continuous backlog and loopback: toggle period = 4 cycles. Each launch decrements `pending` by exactly 1.
